mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Registers the EX-to-MEM bus and selects between the ALU result and the returned data-SRAM load word; loads are byte/half extracted and sign- or zero-extended.
- Drives the MEM-to-WB bus and the MEM bypass outputs to ID.
- A one-entry hold buffer keeps the load data valid across multi-cycle stalls, because the SRAM returns read data only in the first cycle after the request.

Parameters:
- EX_TO_MEM_WD, 76, width of the incoming bus: pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- MEM_TO_WB_WD, 70, width of the outgoing bus: pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- stall  input  6  pipeline stall vector; bit 3 = this stage's register, bit 4 = WB register
- ex_to_mem_bus  input  76  from EX
- ex_load_op  input  3  load type from EX, registered alongside the bus
- data_sram_rdata  input  32  read data, valid one cycle after EX issues the request
- mem_to_wb_bus  output  70  to WB
- mem_wreg  output  1  bypass: write enable
- mem_waddr  output  5  bypass: destination register
- mem_wdata  output  32  bypass: final write data

Behaviour:
- Input register, evaluated on the clk edge in priority order:
  - rst: clear to 0 (register and ex_load_op copy).
  - stall[3]=Stop and stall[4]=NoStop: load all zeros (bubble).
  - stall[3]=NoStop: load ex_to_mem_bus and ex_load_op.
  - Otherwise: hold.
- Zeroed register means rf_we=0, so all outputs are 0 after reset or a bubble.
- load_op encoding:
  - 000 LW
  - 001 LB
  - 010 LBU
  - 011 LH
  - 100 LHU
  - 101..111 treated as LW
- Hold buffer, registers held_valid (1b) and rdata_buf (32b):
  - rst: held_valid <= 0.
  - Any edge where the input register loads (new instruction or bubble): held_valid <= 0.
  - Otherwise, if held_valid=0 and the registered data_ram_en=1 and sel_rf_res=1: rdata_buf <= data_sram_rdata, held_valid <= 1.
  - Net effect: data is captured exactly in the first MEM cycle of a load, then frozen.
- eff_rdata = held_valid ? rdata_buf : data_sram_rdata. Correct both on the first cycle and on every stalled cycle after it.
- Lane select, addr = ex_result[1:0]:
  - Byte = eff_rdata[8*addr+7 : 8*addr].
  - Half = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes eff_rdata unchanged.
  - Misaligned half/word addresses are not checked: half uses addr[1], word ignores addr.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- Stores (data_ram_wen≠0, sel_rf_res=0) pass ex_result; rf_we comes from the bus.
- Output path is combinational from the register.
  - Latency: one cycle from the EX register to the WB bus.
  - No internal back-pressure: stalls come only from the stall vector.
- Reset mid-stall: register and hold buffer clear on the same edge; the next cycle outputs zeros.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: mem_wreg, mem_waddr and mem_wdata are driven from rf_we, rf_waddr and rf_wdata (final, post-extension data), for the ID bypass network.
- Undefined: all three are tied to 0; the ports remain so top-level wiring is unchanged.

Decomposition:
- Shared defines header holds:
  - EX_TO_MEM_WD and MEM_TO_WB_WD
  - StallBus, Stop and NoStop
  - ZeroWord
  - the five LOAD_OP codes
- One natural sub-module: mem_load_align. It is purely combinational: (eff_rdata, addr[1:0], load_op) -> 32b load_data.
- The hold buffer and input register stay in mem_stage.

Test Plan:
- Reset: assert rst 2 cycles with a non-zero bus -> mem_to_wb_bus=0, mem_wreg=0; first non-stalled load after release propagates in 1 cycle.
- ALU pass-through: bus rf_we=1, waddr=5, ex_result=0x1234_5678, sel_rf_res=0 -> next cycle wdata=0x1234_5678, waddr=5, rf_we=1.
- Load extension: rdata=0x80FF_7F01:
  - LB addr=0 -> 0x0000_0001
  - LB addr=3 -> 0xFFFF_FF80
  - LBU addr=3 -> 0x0000_0080
  - LH addr=2 -> 0xFFFF_80FF
  - LHU addr=0 -> 0x0000_7F01
  - LW -> 0x80FF_7F01
- Stall hold: LW with rdata=0xCAFE_F00D in the first MEM cycle, then stall[3]=stall[4]=Stop for 3 cycles while rdata changes to 0xDEAD_BEEF -> wdata stays 0xCAFE_F00D every cycle.
- Bubble: stall[3]=Stop, stall[4]=NoStop -> next cycle rf_we=0, bus all zeros, held_valid=0.
- Bypass with MEM_FWD_EN: LBU waddr=9 -> mem_wreg=1, mem_waddr=9, mem_wdata equals extended data. Without the macro, all three stay 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and load-op codes for the MIPS memory stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 76;
    localparam int MEM_TO_WB_WD = 70;
    localparam int StallBus     = 6;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LBU = 3'b010;
    localparam logic [2:0] LOAD_LH  = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    // Field order matches the EX bus bit layout, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of the returned SRAM word.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves/words are not trapped: halves use addr[1], words ignore addr.
    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (load_op)
            LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: load_data = {24'h0, byte_sel};
            LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: load_data = {16'h0, half_sel};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX->MEM register, load-data hold buffer, WB bus and ID bypass.
// MEM_FWD_EN drives the bypass outputs; without it they are tied to zero.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [2:0]              ex_load_op,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic                    mem_wreg,
    output logic [4:0]              mem_waddr,
    output logic [31:0]             mem_wdata
);

    ex_to_mem_t ex_r;
    mem_to_wb_t wb;
    logic [2:0]  load_op_r;
    logic        held_valid;
    logic [31:0] rdata_buf;
    logic [31:0] eff_rdata;
    logic [31:0] load_data;
    logic        bubble;
    logic        reg_load;

    assign bubble   = (stall[3] == Stop) && (stall[4] == NoStop);
    assign reg_load = bubble || (stall[3] == NoStop);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r      <= '0;
            load_op_r <= '0;
        end else if (bubble) begin
            ex_r      <= '0;
            load_op_r <= '0;
        end else if (stall[3] == NoStop) begin
            ex_r      <= ex_to_mem_bus;
            load_op_r <= ex_load_op;
        end
    end

    // SRAM data is only valid in the first MEM cycle; freeze it for the rest of a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
        end else if (reg_load) begin
            held_valid <= 1'b0;
        end else if (!held_valid && ex_r.data_ram_en && ex_r.sel_rf_res) begin
            rdata_buf  <= data_sram_rdata;
            held_valid <= 1'b1;
        end
    end

    assign eff_rdata = held_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata     (eff_rdata),
        .addr      (ex_r.ex_result[1:0]),
        .load_op   (load_op_r),
        .load_data (load_data)
    );

    always_comb begin
        wb.pc       = ex_r.pc;
        wb.rf_we    = ex_r.rf_we;
        wb.rf_waddr = ex_r.rf_waddr;
        wb.rf_wdata = ex_r.sel_rf_res ? load_data : ex_r.ex_result;
    end

    assign mem_to_wb_bus = wb;

`ifdef MEM_FWD_EN
    assign mem_wreg  = wb.rf_we;
    assign mem_waddr = wb.rf_waddr;
    assign mem_wdata = wb.rf_wdata;
`else
    assign mem_wreg  = 1'b0;
    assign mem_waddr = 5'd0;
    assign mem_wdata = ZeroWord;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB/bypass values queued at drive time.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [StallBus-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [2:0]              ex_load_op;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic                    mem_wreg;
    logic [4:0]              mem_waddr;
    logic [31:0]             mem_wdata;

    typedef struct {
        logic [69:0] bus;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [5:0] RUN    = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b011000;
    localparam logic [5:0] BUBBLE = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_load_op      (ex_load_op),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_wreg        (mem_wreg),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [75:0] mk_bus(logic [31:0] pc, logic en, logic [3:0] wen,
                                           logic sel, logic we, logic [4:0] wa, logic [31:0] res);
        return {pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic exp_t mk_exp(logic [31:0] pc, logic we, logic [4:0] wa, logic [31:0] wd);
        exp_t e;
        e.bus = {pc, we, wa, wd};
`ifdef MEM_FWD_EN
        e.wreg  = we;
        e.waddr = wa;
        e.wdata = wd;
`else
        e.wreg  = 1'b0;
        e.waddr = 5'd0;
        e.wdata = 32'd0;
`endif
        return e;
    endfunction

    // One pipeline cycle: drive at negedge, present SRAM data in the MEM cycle, then compare.
    task automatic cycle(input logic r, input logic [5:0] st, input logic [75:0] bus,
                         input logic [2:0] lop, input logic [31:0] rd, input exp_t e,
                         input string tag);
        exp_t got_e;
        @(negedge clk);
        rst           = r;
        stall         = st;
        ex_to_mem_bus = bus;
        ex_load_op    = lop;
        exp_q.push_back(e);
        @(posedge clk);
        #1 data_sram_rdata = rd;
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = exp_q.pop_front();
            chk({tag, "/bus"},   mem_to_wb_bus,             got_e.bus);
            chk({tag, "/wreg"},  {69'd0, mem_wreg},         {69'd0, got_e.wreg});
            chk({tag, "/waddr"}, {65'd0, mem_waddr},        {65'd0, got_e.waddr});
            chk({tag, "/wdata"}, {38'd0, mem_wdata},        {38'd0, got_e.wdata});
        end
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst             = 1'b1;
        stall           = RUN;
        ex_to_mem_bus   = '0;
        ex_load_op      = 3'd0;
        data_sram_rdata = 32'h0;

        // Reset held with a live bus: outputs stay zero.
        cycle(1, RUN, mk_bus(32'hBFC0_0000, 1, 4'h0, 1, 1, 5'd3, 32'h10), LOAD_LW, 32'h5555_AAAA,
              mk_exp(0, 0, 0, 0), "rst0");
        cycle(1, RUN, mk_bus(32'hBFC0_0000, 1, 4'h0, 1, 1, 5'd3, 32'h10), LOAD_LW, 32'h5555_AAAA,
              mk_exp(0, 0, 0, 0), "rst1");
        // First load after release appears one cycle later.
        cycle(0, RUN, mk_bus(32'hBFC0_0004, 1, 4'h0, 1, 1, 5'd3, 32'h10), LOAD_LW, 32'h1357_9BDF,
              mk_exp(32'hBFC0_0004, 1, 5'd3, 32'h1357_9BDF), "first_lw");

        // ALU pass-through and store.
        cycle(0, RUN, mk_bus(32'hBFC0_0008, 0, 4'h0, 0, 1, 5'd5, 32'h1234_5678), LOAD_LW, 32'hFFFF_FFFF,
              mk_exp(32'hBFC0_0008, 1, 5'd5, 32'h1234_5678), "alu");
        cycle(0, RUN, mk_bus(32'hBFC0_000C, 1, 4'hF, 0, 0, 5'd0, 32'h0000_0100), LOAD_LW, 32'hFFFF_FFFF,
              mk_exp(32'hBFC0_000C, 0, 5'd0, 32'h0000_0100), "store");

        // Load extension on a fixed word.
        cycle(0, RUN, mk_bus(32'h10, 1, 4'h0, 1, 1, 5'd1, 32'h100), LOAD_LB,  RD,
              mk_exp(32'h10, 1, 5'd1, 32'h0000_0001), "lb_a0");
        cycle(0, RUN, mk_bus(32'h14, 1, 4'h0, 1, 1, 5'd2, 32'h103), LOAD_LB,  RD,
              mk_exp(32'h14, 1, 5'd2, 32'hFFFF_FF80), "lb_a3");
        cycle(0, RUN, mk_bus(32'h18, 1, 4'h0, 1, 1, 5'd9, 32'h103), LOAD_LBU, RD,
              mk_exp(32'h18, 1, 5'd9, 32'h0000_0080), "lbu_a3");
        cycle(0, RUN, mk_bus(32'h1C, 1, 4'h0, 1, 1, 5'd4, 32'h102), LOAD_LH,  RD,
              mk_exp(32'h1C, 1, 5'd4, 32'hFFFF_80FF), "lh_a2");
        cycle(0, RUN, mk_bus(32'h20, 1, 4'h0, 1, 1, 5'd6, 32'h100), LOAD_LHU, RD,
              mk_exp(32'h20, 1, 5'd6, 32'h0000_7F01), "lhu_a0");
        cycle(0, RUN, mk_bus(32'h24, 1, 4'h0, 1, 1, 5'd7, 32'h100), LOAD_LW,  RD,
              mk_exp(32'h24, 1, 5'd7, RD), "lw");
        cycle(0, RUN, mk_bus(32'h28, 1, 4'h0, 1, 1, 5'd8, 32'h101), 3'b111,   RD,
              mk_exp(32'h28, 1, 5'd8, RD), "op7_lw");
        cycle(0, RUN, mk_bus(32'h2C, 1, 4'h0, 1, 1, 5'd10, 32'h101), LOAD_LB, RD,
              mk_exp(32'h2C, 1, 5'd10, 32'h0000_007F), "lb_a1");

        // Multi-cycle stall: first-cycle data must persist while the SRAM output changes.
        cycle(0, RUN, mk_bus(32'h40, 1, 4'h0, 1, 1, 5'd11, 32'h200), LOAD_LW, 32'hCAFE_F00D,
              mk_exp(32'h40, 1, 5'd11, 32'hCAFE_F00D), "hold0");
        for (int i = 0; i < 3; i++)
            cycle(0, HOLD, mk_bus(32'h44, 0, 4'h0, 0, 1, 5'd12, 32'h7), LOAD_LW, 32'hDEAD_BEEF,
                  mk_exp(32'h40, 1, 5'd11, 32'hCAFE_F00D), $sformatf("hold%0d", i + 1));

        // Bubble: register zeroed and hold buffer released.
        cycle(0, BUBBLE, mk_bus(32'h44, 0, 4'h0, 0, 1, 5'd12, 32'h7), LOAD_LW, 32'hDEAD_BEEF,
              mk_exp(0, 0, 0, 0), "bubble");
        chk("bubble/held_valid", {69'd0, dut.held_valid}, 70'd0);
        // Next load must see live SRAM data, not the stale buffered word.
        cycle(0, RUN, mk_bus(32'h48, 1, 4'h0, 1, 1, 5'd13, 32'h202), LOAD_LHU, 32'h0BAD_F00D,
              mk_exp(32'h48, 1, 5'd13, 32'h0000_0BAD), "after_bubble");

        // Reset in the middle of a stall clears register and buffer together.
        cycle(0, RUN, mk_bus(32'h50, 1, 4'h0, 1, 1, 5'd14, 32'h300), LOAD_LW, 32'hCAFE_F00D,
              mk_exp(32'h50, 1, 5'd14, 32'hCAFE_F00D), "pre_rst");
        cycle(0, HOLD, mk_bus(32'h54, 0, 4'h0, 0, 1, 5'd15, 32'h9), LOAD_LW, 32'h1111_2222,
              mk_exp(32'h50, 1, 5'd14, 32'hCAFE_F00D), "pre_rst_hold");
        cycle(1, HOLD, mk_bus(32'h54, 0, 4'h0, 0, 1, 5'd15, 32'h9), LOAD_LW, 32'h1111_2222,
              mk_exp(0, 0, 0, 0), "rst_mid_stall");
        chk("rst_mid_stall/held_valid", {69'd0, dut.held_valid}, 70'd0);
        cycle(0, RUN, mk_bus(32'h58, 1, 4'h0, 1, 1, 5'd16, 32'h400), LOAD_LW, 32'h3333_4444,
              mk_exp(32'h58, 1, 5'd16, 32'h3333_4444), "post_rst_lw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
